// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and counter sizing for serial_adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter width: clog2 of the slice count, never narrower than one bit
  function automatic int cnt_width(input int width, input int digit);
    return ($clog2(width / digit) < 1) ? 1 : $clog2(width / digit);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// fa_cell: stateless 1-bit full adder
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder, DIGIT bits per cycle; SERIAL_ADDER_SUB_EN adds a subtract port
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  state_t           state;
  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic             carry, cout_r, ovf_r, inv;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] s, bx;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_r;
  assign inv = sub_r;
`else
  assign inv = 1'b0;
`endif

  // Subtraction adds the one's complement of b; the +1 arrives as the initial carry
  assign bx   = b_r[DIGIT-1:0] ^ {DIGIT{inv}};
  assign c[0] = carry;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    fa_cell u_fa (
      .a   (a_r[i]),
      .b   (bx[i]),
      .cin (c[i]),
      .sum (s[i]),
      .cout(c[i+1])
    );
  end

  // Control: accept in IDLE, count slices in RUN, hold the result in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state <= RUN;
          cnt   <= '0;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operands: captured on accept, shifted down one slice per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_r <= 1'b0;
`endif
    end else if (state == IDLE && in_valid) begin
      a_r   <= a;
      b_r   <= b;
`ifdef SERIAL_ADDER_SUB_EN
      sub_r <= sub;
      carry <= sub ? 1'b1 : cin;
`else
      carry <= cin;
`endif
    end else if (state == RUN) begin
      a_r   <= a_r >> DIGIT;
      b_r   <= b_r >> DIGIT;
      carry <= c[DIGIT];
    end
  end

  // Result: slices enter at the top so the LSB slice lands at bit 0 after the last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (state == RUN) begin
      sum_r <= (sum_r >> DIGIT) | (WIDTH'(s) << (WIDTH - DIGIT));
      if (cnt == LAST) begin
        cout_r <= c[DIGIT];
        ovf_r  <= c[DIGIT] ^ c[DIGIT-1];
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed bench for serial_adder (8x1 and 16x4 instances) with an arithmetic reference model
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv8 = 0, or8 = 0, cin8 = 0, sub8 = 0, ir8, ov8, co8, of8;
  logic [7:0]  a8 = 0, b8 = 0, s8;
  logic        iv16 = 0, or16 = 0, cin16 = 0, sub16 = 0, ir16, ov16, co16, of16;
  logic [15:0] a16 = 0, b16 = 0, s16;

  int tests = 0;
  int fails = 0;

  serial_adder #(.WIDTH(8), .DIGIT(1)) d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(cin16),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub16),
`endif
    .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(of16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic: {ovf, cout, sum} of a w-bit add, subtract as a + ~b + 1
  function automatic logic [17:0] ref_add(input int w, input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic sb);
    logic [16:0] m, t;
    logic [15:0] yy;
    logic        cc, sm;
    m  = (17'd1 << w) - 17'd1;
    yy = sb ? ~y : y;
    cc = sb ? 1'b1 : c;
    t  = ({1'b0, x} & m) + ({1'b0, yy} & m) + {16'd0, cc};
    sm = t[w-1];
    return {(x[w-1] == yy[w-1]) && (sm != x[w-1]), t[w], t[15:0] & m[15:0]};
  endfunction

  logic msub8, msub16;
`ifdef SERIAL_ADDER_SUB_EN
  assign msub8  = sub8;
  assign msub16 = sub16;
`else
  assign msub8  = 1'b0;
  assign msub16 = 1'b0;
`endif

  // Transaction-level model: busy from accept until the result is taken; result visible STEPS edges after accept
  logic        m8_busy, m16_busy;
  int          m8_age, m16_age;
  logic [17:0] e8, e16;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8_busy <= 0;
      m8_age  <= 0;
    end else if (!m8_busy) begin
      if (iv8) begin
        m8_busy <= 1;
        m8_age  <= 0;
        e8      <= ref_add(8, {8'd0, a8}, {8'd0, b8}, cin8, msub8);
      end
    end else if (m8_age < 8) m8_age <= m8_age + 1;
    else if (or8) m8_busy <= 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m16_busy <= 0;
      m16_age  <= 0;
    end else if (!m16_busy) begin
      if (iv16) begin
        m16_busy <= 1;
        m16_age  <= 0;
        e16      <= ref_add(16, a16, b16, cin16, msub16);
      end
    end else if (m16_age < 4) m16_age <= m16_age + 1;
    else if (or16) m16_busy <= 0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ir8", ir8, !m8_busy);
      chk("ov8", ov8, m8_busy && m8_age == 8);
      if (m8_busy && m8_age == 8) begin
        chk("sum8", s8, e8[7:0]);
        chk("cout8", co8, e8[16]);
        chk("ovf8", of8, e8[17]);
      end
      chk("ir16", ir16, !m16_busy);
      chk("ov16", ov16, m16_busy && m16_age == 4);
      if (m16_busy && m16_age == 4) begin
        chk("sum16", s16, e16[15:0]);
        chk("cout16", co16, e16[16]);
        chk("ovf16", of16, e16[17]);
      end
    end
  end

  // One operation on the selected instance; literal checks when lit=1, then the result is released
  task automatic op(input int d, input logic [15:0] x, input logic [15:0] y, input logic c,
                    input logic sb, input int lat, input logic lit, input logic [15:0] es,
                    input logic ec, input logic eo);
    int n;
    @(negedge clk);
    if (d == 8) begin
      iv8 = 1; a8 = x[7:0]; b8 = y[7:0]; cin8 = c; sub8 = sb;
    end else begin
      iv16 = 1; a16 = x; b16 = y; cin16 = c; sub16 = sb;
    end
    @(posedge clk);
    #1;
    iv8 = 0; iv16 = 0;
    n = 0;
    while (!(d == 8 ? ov8 : ov16) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, lat);
    if (lit) begin
      chk("lit_sum", d == 8 ? {8'd0, s8} : s16, es);
      chk("lit_cout", d == 8 ? co8 : co16, ec);
      chk("lit_ovf", d == 8 ? of8 : of16, eo);
    end
    @(negedge clk);
    or8 = 1; or16 = 1;
    @(posedge clk);
    #1;
    or8 = 0; or16 = 0;
    chk("idle_after", d == 8 ? ir8 : ir16, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ov", ov8, 0);
    chk("rst_sum", s8, 0);
    chk("rst_cout", co8, 0);
    chk("rst_ovf", of8, 0);
    chk("rst_sum16", s16, 0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_ir", ir8, 1);

    op(8, 16'h00FF, 16'h0001, 0, 0, 8, 1, 16'h0000, 1, 0);
    op(8, 16'h007F, 16'h0001, 0, 0, 8, 1, 16'h0080, 0, 1);
    op(8, 16'h0080, 16'h0080, 1, 0, 8, 1, 16'h0001, 1, 1);

    // Backpressure: result held while the consumer stalls and inputs churn
    @(negedge clk);
    iv8 = 1; a8 = 8'h21; b8 = 8'h43; cin8 = 0; sub8 = 0;
    @(posedge clk);
    #1;
    repeat (8) begin
      iv8 = ~iv8; a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv8 = ~iv8; a8 = 8'($urandom); b8 = 8'($urandom);
      chk("bp_sum", s8, 8'h64);
      chk("bp_ir", ir8, 0);
      chk("bp_ov", ov8, 1);
    end
    @(negedge clk);
    iv8 = 1; or8 = 1;
    @(posedge clk);
    #1;
    iv8 = 0; or8 = 0;
    chk("bp_idle", ir8, 1);
    @(negedge clk);
    chk("bp_no_accept", ir8, 1);

    // Reset in the middle of RUN
    @(negedge clk);
    iv8 = 1; a8 = 8'h55; b8 = 8'h11;
    @(posedge clk);
    #1;
    iv8 = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 0;
    #2;
    chk("mid_rst_ov", ov8, 0);
    chk("mid_rst_ir", ir8, 1);
    chk("mid_rst_sum", s8, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_ov", ov8, 0);
    end
    op(8, 16'h0012, 16'h0034, 0, 0, 8, 1, 16'h0046, 0, 0);

    op(16, 16'hFFFF, 16'h0001, 0, 0, 4, 1, 16'h0000, 1, 0);
    op(16, 16'h7FFF, 16'h0001, 1, 0, 4, 1, 16'h8001, 0, 1);

`ifdef SERIAL_ADDER_SUB_EN
    op(8, 16'h0005, 16'h0007, 1, 1, 8, 1, 16'h00FE, 0, 0);
    op(8, 16'h0080, 16'h0001, 0, 1, 8, 1, 16'h007F, 1, 1);
    op(16, 16'h1234, 16'h1234, 0, 1, 4, 1, 16'h0000, 1, 0);
`endif

    for (int i = 0; i < 6; i++) begin
      op(8, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 8, 0, 0, 0, 0);
      op(16, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 4, 0, 0, 0, 0);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001: Parameter WIDTH, default 8, sets the operand and result width in bits; it SHALL be at least 2.
REQ-002: Parameter DIGIT, default 1, sets the bits added per cycle; it SHALL divide WIDTH exactly.
REQ-003: One clock, and the reset is asynchronous and active-low.
REQ-004: The ports SHALL be as follows, one per line, in this order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- sub  in  1  subtract select; this port exists only under SERIAL_ADDER_SUB_EN.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of the MSB.
- ovf  out  1  signed overflow, computed as carry into MSB XOR carry out of MSB.

Function
REQ-005: The FSM SHALL have three states, IDLE, RUN and DONE, defined as follows:
- IDLE: in_ready=1, out_valid=0.
- RUN: in_ready=0, out_valid=0.
- DONE: in_ready=0, out_valid=1.
REQ-006: In IDLE, when in_valid=1, the block SHALL latch a, b and cin into internal registers, clear the digit counter, and go to RUN.
REQ-007: In RUN, each cycle SHALL add one DIGIT-bit slice, LSB slice first, with the carry registered between slices.
REQ-008: RUN SHALL last exactly WIDTH/DIGIT cycles, after which the FSM goes to DONE.
REQ-009: Latency: if operands are accepted at edge T, out_valid SHALL rise at edge T+WIDTH/DIGIT.
REQ-010: In DONE, sum, cout and ovf SHALL hold stable while out_ready=0; there is no timeout.
REQ-011: In DONE, out_ready=1 SHALL complete the transfer and return the FSM to IDLE on the next edge.
REQ-012: in_ready is low in DONE, so in_valid in the same cycle as out_ready SHALL NOT be accepted; the earliest next accept is one cycle later.
REQ-013: in_valid and any operand changes during RUN or DONE SHALL be ignored.
REQ-014: Arithmetic SHALL be modulo 2^WIDTH; cout and ovf are reported separately.
REQ-015: With cin=0, WIDTH=8, a=0xFF, b=0x01, the result SHALL be sum=0x00, cout=1, ovf=0.

Reset
REQ-016: rst_n low SHALL take effect immediately, independent of clk.
REQ-017: On reset, the FSM SHALL go to IDLE, and in_ready SHALL become 1 once rst_n is released.
REQ-018: On reset, out_valid SHALL be 0, sum SHALL be 0, cout SHALL be 0, ovf SHALL be 0, and the counter and carry registers SHALL be 0.
REQ-019: Reset during RUN or DONE SHALL abort the operation with no out_valid pulse; the partial result is discarded.

Configuration
REQ-020: Macro SERIAL_ADDER_SUB_EN SHALL compile subtraction support in or out, as follows:
- Defined: the sub port exists and is latched together with the operands.
- Defined, sub=1: the block computes a-b as a + ~b + 1, cin is ignored, cout=1 means no borrow, and ovf follows REQ-004.
- Undefined: the sub port is absent and the block performs addition only; results SHALL equal those of a defined build with sub=0.

Structure
REQ-021: Package serial_adder_pkg SHALL hold the state enum type (IDLE/RUN/DONE) and the function computing the counter width as clog2(WIDTH/DIGIT).
REQ-022: Sub-module fa_cell SHALL be the 1-bit full adder (a, b, cin -> sum, cout) with no state; serial_adder SHALL instantiate DIGIT of them in a ripple chain per slice.
REQ-023: All state, counter, operand shift registers and result registers SHALL live in serial_adder.

Verification
REQ-024: WIDTH=8, DIGIT=1: a=0xFF, b=0x01, cin=0 accepted at edge T -> out_valid at T+8, sum=0x00, cout=1, ovf=0.
REQ-025: WIDTH=8, DIGIT=1: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; a=0x80, b=0x80, cin=1 -> sum=0x01, cout=1, ovf=1.
REQ-026: Backpressure: hold out_ready=0 for 5 cycles in DONE, toggling in_valid, a and b throughout -> sum stable and in_ready=0 for all 5 cycles; out_ready=1 then gives IDLE on the next edge.
REQ-027: Reset mid-operation: assert rst_n=0 at RUN digit 3 -> out_valid=0 and in_ready=1 after release; a fresh operation 0x12+0x34 then gives 0x46.
REQ-028: WIDTH=16, DIGIT=4: a=0xFFFF, b=0x0001, cin=0 -> out_valid 4 cycles after accept, sum=0x0000, cout=1.
REQ-029: SERIAL_ADDER_SUB_EN defined, sub=1, WIDTH=8: a=0x05, b=0x07 -> sum=0xFE, cout=0, ovf=0; a=0x80, b=0x01 -> sum=0x7F, ovf=1.
